// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select pair of a shared 4:1 mux.
// Grants one requester at a time with rotating priority and a bounded hold time.
module rr_mux_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       valid,
  output logic [1:0] owner,
  output logic       s1,
  output logic       s2
);

  localparam int unsigned     CW      = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(HOLD_MAX - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q;
  logic [3:0]    grant_q;
  logic [1:0]    owner_q;
  logic [1:0]    ptr_q;
  logic [CW-1:0] cnt_q;

  logic [1:0]    win_d;
  logic [1:0]    ptr_d;
  logic [3:0]    grant_d;
  logic          any_req;
  logic          others;
  logic          owner_req;
  logic          hold_done;

  // First requester found scanning from ptr_q upward with wraparound.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win_d = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        win_d = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    any_req   = |req;
    others    = |(req & ~grant_q);
    owner_req = req[owner_q];
    hold_done = (cnt_q == CNT_MAX);
    ptr_d     = win_d + 2'd1;
    grant_d   = 4'(1) << win_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= BUSY;
            grant_q <= grant_d;
            owner_q <= win_d;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          // Release and hold expiry both hand over; owner/ptr stay put on idle.
          if ((!owner_req && others) || (owner_req && hold_done && others)) begin
            grant_q <= grant_d;
            owner_q <= win_d;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
          end else if (!owner_req) begin
            state_q <= IDLE;
            grant_q <= '0;
          end else if (!hold_done) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign valid = (state_q == BUSY);
  assign owner = owner_q;
  assign s1    = owner_q[0];
  assign s2    = owner_q[1];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: HOLD_MAX=8 and HOLD_MAX=1 instances
// checked each cycle against a queue of expected outputs from a reference model.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req8 = '0;
  logic [3:0] req1 = '0;

  logic [3:0] g8, g1;
  logic       v8, v1;
  logic [1:0] o8, o1;
  logic       s1_8, s2_8, s1_1, s2_1;

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [8:0] q1[$];

  int unsigned hold_lim[2] = '{8, 1};
  bit m_busy[2];
  int m_owner[2];
  int m_ptr[2];
  int m_held[2];

  rr_mux_arbiter #(.HOLD_MAX(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .grant(g8), .valid(v8),
    .owner(o8), .s1(s1_8), .s2(s2_8)
  );

  rr_mux_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .grant(g1), .valid(v1),
    .owner(o1), .s1(s1_1), .s2(s2_1)
  );

  always #5 clk = ~clk;

  function automatic void m_reset(int k);
    m_busy[k]  = 1'b0;
    m_owner[k] = 0;
    m_ptr[k]   = 0;
    m_held[k]  = 0;
  endfunction

  function automatic int pick(int ptr, logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  function automatic void m_grant(int k, int w);
    m_busy[k]  = 1'b1;
    m_owner[k] = w;
    m_ptr[k]   = (w + 1) % 4;
    m_held[k]  = 1;
  endfunction

  // m_held counts cycles the current owner has had the grant visible.
  function automatic void m_step(int k, logic [3:0] r);
    bit others = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != m_owner[k] && r[i]) others = 1'b1;
    end
    if (!m_busy[k]) begin
      if (r != 4'b0000) m_grant(k, pick(m_ptr[k], r));
    end else if (!r[m_owner[k]]) begin
      if (others) m_grant(k, pick(m_ptr[k], r));
      else m_busy[k] = 1'b0;
    end else if (m_held[k] >= int'(hold_lim[k]) && others) begin
      m_grant(k, pick(m_ptr[k], r));
    end else if (m_held[k] < int'(hold_lim[k])) begin
      m_held[k] = m_held[k] + 1;
    end
  endfunction

  function automatic logic [8:0] m_exp(int k);
    logic [3:0] g;
    logic [1:0] o;
    o = 2'(m_owner[k]);
    g = m_busy[k] ? (4'b0001 << o) : 4'b0000;
    return {g, m_busy[k], o, o[0], o[1]};
  endfunction

  function automatic void compare(string name, logic [8:0] exp, logic [8:0] act);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s outputs: got grant=%b valid=%b owner=%0d s2s1=%b%b, expected grant=%b valid=%b owner=%0d s2s1=%b%b",
               name, act[8:5], act[4], act[3:2], act[0], act[1],
               exp[8:5], exp[4], exp[3:2], exp[0], exp[1]);
    end
  endfunction

  // Monitor: samples outputs on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q8.size() > 0) compare("hold8", q8.pop_front(), {g8, v8, o8, s1_8, s2_8});
      if (q1.size() > 0) compare("hold1", q1.pop_front(), {g1, v1, o1, s1_1, s2_1});
    end
  end

  task automatic step(input logic [3:0] r8, input logic [3:0] r1);
    req8 = r8;
    req1 = r1;
    @(posedge clk);
    if (rst_n) begin
      m_step(0, r8);
      m_step(1, r1);
    end
    q8.push_back(m_exp(0));
    q1.push_back(m_exp(1));
    @(negedge clk);
  endtask

  task automatic steps(input int n, input logic [3:0] r8, input logic [3:0] r1);
    for (int i = 0; i < n; i++) step(r8, r1);
  endtask

  // Reset pulse between edges, spanning the sampling point so the clear must be asynchronous.
  task automatic step_rst(input logic [3:0] r8, input logic [3:0] r1);
    req8 = r8;
    req1 = r1;
    @(posedge clk);
    m_step(0, r8);
    m_step(1, r1);
    q8.push_back(m_exp(0));
    q1.push_back(m_exp(1));
    #2;
    rst_n = 1'b0;
    m_reset(0);
    m_reset(1);
    void'(q8.pop_back());
    void'(q1.pop_back());
    q8.push_back(m_exp(0));
    q1.push_back(m_exp(1));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset(0);
    m_reset(1);

    steps(2, 4'b1111, 4'b1111);
    rst_n = 1'b1;

    // Full contention on the HOLD_MAX=8 unit; alternating pair on HOLD_MAX=1.
    steps(40, 4'b1111, 4'b1010);
    steps(2, 4'b0000, 4'b0000);

    // Single requester, then release; HOLD_MAX=1 holder keeps the grant.
    steps(5, 4'b0100, 4'b0010);
    steps(3, 4'b0000, 4'b0010);
    steps(2, 4'b0000, 4'b0000);

    // Early release handover, then skip over a non-requester.
    step(4'b0001, 4'b0000);
    steps(3, 4'b1011, 4'b1010);
    steps(4, 4'b1010, 4'b1010);
    steps(3, 4'b1000, 4'b0010);
    steps(2, 4'b0000, 4'b0000);

    // Reset mid-grant, then ptr restarts at 0.
    steps(5, 4'b0100, 4'b0100);
    step_rst(4'b0100, 4'b0100);
    steps(3, 4'b1100, 4'b1100);

    // Randomized phase with held patterns so hold expiry is exercised.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r8;
      logic [3:0] r1;
      r8 = req8;
      r1 = req1;
      if ($urandom_range(0, 5) == 0) r8 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r1 = 4'($urandom_range(0, 15));
      step(r8, r1);
    end

    @(posedge clk);
    checks++;
    if (q8.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending entries, expected 0/0", q8.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares the four-input, one-output select mux among four requesters. It samples four request lines and grants the mux to one requester at a time, with fair rotation and a bounded hold time. It drives the mux select pair (s1 low-order, s2 high-order) from the registered grant. It sits directly in front of the 4:1 mux and is the only agent that drives its selects.

## Interface
- HOLD_MAX, 8: max consecutive cycles one owner keeps the grant while another requester waits; legal range 1..256.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  level requests; bit0=a, bit1=b, bit2=c, bit3=d.
- grant  output  4  one-hot registered grant; all-zero when idle.
- valid  output  1  high when grant is non-zero.
- owner  output  2  index of current or last owner (0=a..3=d).
- s1  output  1  mux low select = owner[0].
- s2  output  1  mux high select = owner[1].

## Operation
- States: IDLE (no grant), BUSY (one grant active).
- Rotation pointer ptr (2 bits) = index searched first. On reset ptr=0. On every new grant, ptr becomes (winner+1) mod 4.
- Winner = first set bit of req, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Hold counter cnt, width ceil(log2(HOLD_MAX)) (min 1). It clears to 0 on each new grant and increments each BUSY cycle. It saturates at HOLD_MAX-1.
- Transitions:
  - IDLE: req==0 -> stay IDLE. Otherwise go to BUSY and grant the winner.
  - BUSY, req[owner]=0: if any other req is set, hand over directly to the winner with no idle bubble. Otherwise go to IDLE.
  - BUSY, req[owner]=1, cnt==HOLD_MAX-1, another req set: hand over to the winner. The scan starts at ptr, so the current owner is never re-selected.
  - BUSY, req[owner]=1, otherwise: keep the grant.
- owner, s1 and s2 keep their last value in IDLE. The mux output therefore does not glitch on release.
- grant, owner, s1 and s2 change only on clock edges and are always mutually consistent.
- Requests are sampled only at clock edges. A pulse shorter than one cycle between edges is ignored.
- Reset asserted mid-grant clears all state immediately (asynchronously). After release, the first grant uses ptr=0.

## Timing
- Reset values: grant=0000, valid=0, owner=00, s1=0, s2=0, state=IDLE, ptr=0, cnt=0.
- Request-to-grant latency: 1 cycle. req seen at edge k gives grant visible after edge k.
- Release latency: 1 cycle. req[owner] low at edge k gives grant cleared or handed over after edge k.
- Under full contention each requester holds for exactly HOLD_MAX cycles. With HOLD_MAX=1 the grant rotates every cycle.
- Worst-case wait for a continuously asserted request: 3*HOLD_MAX + 1 cycles.
- Simultaneous owner release and hold expiry: the release rule applies. Either way the result is a handover to the winner.
- No combinational path from req to any output.

## Test plan
- Reset: hold rst_n=0 with req=1111 -> grant=0000, valid=0, s1=s2=0. Release -> grant=0001 (a) after the first edge.
- Single request: req=0100 for 5 cycles, then 0 -> grant=0100 one cycle after assert, s1=0, s2=1 for 5 cycles. Then grant=0000, valid=0, s1=0 and s2=1 retained.
- Full contention, HOLD_MAX=8: req=1111 for 40 cycles -> grant sequence a,b,c,d,a with each lasting exactly 8 cycles. {s2,s1} follows 00,01,10,11,00.
- Early release handover: a owns, b and d requesting, a drops after 3 cycles -> grant=0010 on the next edge with no valid=0 cycle. When b later drops, grant goes to d (skipping c, which is not requesting).
- HOLD_MAX=1: req=1010 steady -> grant alternates 0010, 1000 every cycle. Then req=0010 only -> b holds indefinitely with cnt saturated.
- Reset mid-grant: c owns with cnt=4, rst_n pulsed low between edges -> outputs return to reset values asynchronously. Then req=1100 -> grant=0100 (ptr restarts at 0, so c wins over d).
